instr_mem_responder: RTL and testbench
======================================

# instr_mem_responder

Responder end of the instruction-fetch request/response protocol. It services single-instruction fetch requests from `instr_fetcher` against a fixed-latency-agnostic 32-bit instruction memory port with no caching and no translation. Halfword-aligned PCs and 32-bit instructions that straddle a word boundary are supported. It replaces the instruction cache in bare-metal and simulation configurations.

## Interface
- `XLEN`, 64, address width.
- `MEM_BASE`, 0, byte base address of the instruction memory.
- `MEM_SIZE`, 'h10000, memory size in bytes; a multiple of 4.

- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  fetch request strobe; the block is always ready
- `req_pc`  in  XLEN  fetch PC; bit 0 is ignored
- `req_reason`  in  if_reason_t  accepted; no effect (no cache state to flush)
- `req_prv`, `req_sum`  in  1  accepted; no effect
- `req_atp`  in  XLEN  MODE field is `req_atp[XLEN-1:XLEN-4]`
- `resp_valid`  out  1  single-cycle response pulse
- `resp_instr`  out  32  instruction; upper 16 bits are zero for a compressed instruction
- `resp_pc`  out  XLEN  PC of the responded request
- `resp_exception`  out  1  fetch fault; `resp_instr` is don't-care when set
- `mem_req_valid`  out  1  memory read request
- `mem_req_ready`  in  1  memory accepts the request
- `mem_req_addr`  out  XLEN  word-aligned byte address
- `mem_resp_valid`  in  1  read data strobe; in order, exactly one per accepted request
- `mem_resp_data`  in  32  read data, little-endian

## Operation
- **States:** IDLE, ISSUE, WAIT, FAULT.
- **Accept:** every `req_valid` is accepted, in any state, and is latched as pc/atp into the current-request registers.
  - **Fault check:** the request faults if `atp` MODE != 0 (translation unsupported), or if pc is outside [MEM_BASE, MEM_BASE+MEM_SIZE).
    - Faulting request: go to FAULT.
    - Otherwise: go to ISSUE with address `{pc[XLEN-1:2],2'b00}` and the hi-phase flag cleared.
- **ISSUE:**
  - `mem_req_valid`=1.
  - `mem_req_valid` and `mem_req_addr` are held stable until `mem_req_ready`; a superseding request does not change them.
  - On handshake, go to WAIT.
- **WAIT, on `mem_resp_valid`:**
  - **Stale response:** if the stale flag is set, discard the data, clear the flag, and go to ISSUE (or FAULT) for the pending request.
  - **Lo phase, pc[1]=0:** respond with `instr=data`.
  - **Lo phase, pc[1]=1:** let lo = `data[31:16]`.
    - If `lo[1:0]!=2'b11`, respond with `instr={16'b0,lo}`.
    - Otherwise save lo and range-check the next word (pc+2).
      - Out of range: go to FAULT.
      - In range: set the hi-phase flag and go to ISSUE at word address +4.
  - **Hi phase:** respond with `instr={data[15:0],lo}`.
- **Respond:** assert `resp_valid` for one cycle with `resp_pc`=pc, `resp_exception`=0, then go to IDLE.
- **FAULT:** respond with `resp_exception`=1, `resp_pc`=pc, `resp_instr`=0, then go to IDLE.
- **Supersede:** a `req_valid` in ISSUE (after `mem_req_valid` was raised) or in WAIT sets the stale flag.
  - Any response for the old request is suppressed.
  - The old memory request completes and its data is dropped.
- **Supersede in FAULT or respond cycle:** the new request is handled as from IDLE, and the old response is still emitted.
- **In-flight limit:** at most one memory read is in flight at any time.

## Timing
- **Reset values:** all outputs 0; state IDLE; stale, hi-phase and saved-lo registers 0.
- **Registered outputs:** all outputs are registered; there is no combinational path from `req_*` or `mem_resp_*` to any output.
- **Request latency:** `mem_req_valid` is asserted the cycle after an accepted request.
- **Response latency:** `resp_valid` is asserted the cycle after the final `mem_resp_valid`.
- **Minimum latencies:**
  - Single-word fetch: request at cycle 0; mem request at cycle 1 (ready=1); data at cycle 2 (1-cycle memory); response at cycle 3.
  - Straddling fetch: response at cycle 5.
- **Fault latency:** `resp_valid` is asserted the cycle after the request, with no memory activity.
- **Simultaneous supersede and data:** `req_valid` in the same cycle as a non-stale final `mem_resp_valid` discards that data, with no response.
- **Reset mid-operation:** all state clears immediately.
  - A `mem_resp_valid` arriving after reset while in IDLE is ignored.
  - The environment resets memory together with this block.

## Test plan
- **Aligned 32-bit fetch:** pc=0x100, memory word at 0x100 = 0x00A00093 -> one read at 0x100; `resp_instr`=0x00A00093, `resp_pc`=0x100, exception 0.
- **Compressed at pc[1]=1:** pc=0x102, word at 0x100 = 0x4501_0001 -> one read; `resp_instr`=0x00004501.
- **Straddling fetch:** pc=0x102, word at 0x100 = 0x0093_xxxx, word at 0x104 = 0xxxxx_00A0 -> reads at 0x100 then 0x104; `resp_instr`=0x00A00093.
- **Faults:**
  - pc=MEM_BASE+MEM_SIZE -> exception 1 the next cycle, no `mem_req_valid`.
  - atp=0x8000_0000_0000_0000 -> exception 1.
  - pc=MEM_BASE+MEM_SIZE-2 with upper half ending 2'b11 -> exception 1 after one read.
- **Supersede:** request 0x100, mem latency 5, second request 0x200 in WAIT -> exactly one response (pc 0x200, correct data); reads issued 0x100 then 0x200.
- **Backpressure and reset:**
  - `mem_req_ready` low for 4 cycles -> address stable throughout.
  - `rst` asserted in WAIT -> all outputs 0 next edge; no response after release.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: serves single fetches straight from a 32-bit memory port,
// supporting halfword-aligned PCs and 32-bit instructions that straddle a word boundary.
package instr_mem_pkg;
  typedef enum logic [1:0] {
    IF_FETCH   = 2'd0,
    IF_BRANCH  = 2'd1,
    IF_FENCE_I = 2'd2,
    IF_SFENCE  = 2'd3
  } if_reason_t;
endpackage

module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] MEM_BASE = '0,
  parameter logic [XLEN-1:0] MEM_SIZE = XLEN'(17'h10000)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [XLEN-1:0] req_pc,
  input  if_reason_t      req_reason,
  input  logic            req_prv,
  input  logic            req_sum,
  input  logic [XLEN-1:0] req_atp,
  output logic            resp_valid,
  output logic [31:0]     resp_instr,
  output logic [XLEN-1:0] resp_pc,
  output logic            resp_exception,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [31:0]     mem_resp_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FAULT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [3:0]      mode_q, mode_d;
  logic            hi_q, hi_d;
  logic            stale_q, stale_d;
  logic [15:0]     lo_q, lo_d;
  logic            mem_req_valid_q, mem_req_valid_d;
  logic [XLEN-1:0] mem_req_addr_q, mem_req_addr_d;
  logic            resp_valid_q, resp_valid_d;
  logic [31:0]     resp_instr_q, resp_instr_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic            resp_exc_q, resp_exc_d;

  logic            launch, respond, fault_resp, launch_fault;
  logic            req_fault, pend_fault, next_in_range;
  logic [31:0]     rsp_instr;
  logic [XLEN-1:0] pc_even_q, req_pc_even;

  // Sideband fields carry no meaning without a cache or MMU.
  logic unused_inputs;
  assign unused_inputs = ^{req_reason, req_prv, req_sum, req_atp[XLEN-5:0]};

  function automatic logic in_range(input logic [XLEN-1:0] a);
    return (a >= MEM_BASE) && ((a - MEM_BASE) < MEM_SIZE);
  endfunction

  assign req_pc_even   = {req_pc[XLEN-1:1], 1'b0};
  assign pc_even_q     = {pc_q[XLEN-1:1], 1'b0};
  assign req_fault     = (req_atp[XLEN-1:XLEN-4] != 4'd0) || !in_range(req_pc_even);
  assign pend_fault    = (mode_q != 4'd0) || !in_range(pc_even_q);
  assign next_in_range = in_range(pc_even_q + XLEN'(2));

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    mode_d          = mode_q;
    hi_d            = hi_q;
    stale_d         = stale_q;
    lo_d            = lo_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    resp_valid_d    = 1'b0;
    resp_instr_d    = resp_instr_q;
    resp_pc_d       = resp_pc_q;
    resp_exc_d      = resp_exc_q;
    launch          = 1'b0;
    respond         = 1'b0;
    fault_resp      = 1'b0;
    rsp_instr       = '0;

    if (req_valid) begin
      pc_d   = req_pc;
      mode_d = req_atp[XLEN-1:XLEN-4];
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) launch = 1'b1;
      end
      S_FAULT: begin
        state_d = S_IDLE;
        if (req_valid) launch = 1'b1;
      end
      S_ISSUE: begin
        if (req_valid) stale_d = 1'b1;
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          // Superseded or stale data is dropped; the newest request is started instead.
          if (req_valid || stale_q) begin
            launch = 1'b1;
          end else if (hi_q) begin
            respond   = 1'b1;
            rsp_instr = {mem_resp_data[15:0], lo_q};
          end else if (!pc_q[1]) begin
            respond   = 1'b1;
            rsp_instr = mem_resp_data;
          end else if (mem_resp_data[17:16] != 2'b11) begin
            respond   = 1'b1;
            rsp_instr = {16'h0000, mem_resp_data[31:16]};
          end else begin
            lo_d = mem_resp_data[31:16];
            if (!next_in_range) begin
              fault_resp = 1'b1;
            end else begin
              hi_d            = 1'b1;
              mem_req_addr_d  = mem_req_addr_q + XLEN'(4);
              mem_req_valid_d = 1'b1;
              state_d         = S_ISSUE;
            end
          end
        end else if (req_valid) begin
          stale_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    launch_fault = req_valid ? req_fault : pend_fault;
    if (launch) begin
      stale_d = 1'b0;
      hi_d    = 1'b0;
      if (launch_fault) begin
        fault_resp = 1'b1;
      end else begin
        mem_req_addr_d  = {pc_d[XLEN-1:2], 2'b00};
        mem_req_valid_d = 1'b1;
        state_d         = S_ISSUE;
      end
    end

    if (respond) begin
      resp_valid_d = 1'b1;
      resp_instr_d = rsp_instr;
      resp_pc_d    = pc_q;
      resp_exc_d   = 1'b0;
      state_d      = S_IDLE;
    end

    // The fault response is registered on entry so it appears the cycle after the cause.
    if (fault_resp) begin
      resp_valid_d = 1'b1;
      resp_instr_d = '0;
      resp_pc_d    = pc_d;
      resp_exc_d   = 1'b1;
      state_d      = S_FAULT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      pc_q            <= '0;
      mode_q          <= '0;
      hi_q            <= 1'b0;
      stale_q         <= 1'b0;
      lo_q            <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      resp_valid_q    <= 1'b0;
      resp_instr_q    <= '0;
      resp_pc_q       <= '0;
      resp_exc_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      mode_q          <= mode_d;
      hi_q            <= hi_d;
      stale_q         <= stale_d;
      lo_q            <= lo_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      resp_valid_q    <= resp_valid_d;
      resp_instr_q    <= resp_instr_d;
      resp_pc_q       <= resp_pc_d;
      resp_exc_q      <= resp_exc_d;
    end
  end

  assign resp_valid     = resp_valid_q;
  assign resp_instr     = resp_instr_q;
  assign resp_pc        = resp_pc_q;
  assign resp_exception = resp_exc_q;
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_req_addr   = mem_req_addr_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: memory BFM, fetch-level reference model and response scoreboard.
module tb_instr_mem_responder;
  import instr_mem_pkg::*;

  localparam logic [63:0] BASE = 64'h0;
  localparam logic [63:0] SIZE = 64'h10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [63:0] req_pc;
  if_reason_t  req_reason;
  logic        req_prv, req_sum;
  logic [63:0] req_atp;
  logic        resp_valid;
  logic [31:0] resp_instr;
  logic [63:0] resp_pc;
  logic        resp_exception;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  instr_mem_responder #(.XLEN(64), .MEM_BASE(BASE), .MEM_SIZE(SIZE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_pc(req_pc), .req_reason(req_reason),
    .req_prv(req_prv), .req_sum(req_sum), .req_atp(req_atp),
    .resp_valid(resp_valid), .resp_instr(resp_instr), .resp_pc(resp_pc),
    .resp_exception(resp_exception),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents and the fetch-level reference model
  logic [31:0] mem [0:16383];

  typedef struct {
    logic [63:0] pc;
    logic        exc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  function automatic exp_t model(input logic [63:0] pc, input logic [63:0] atp);
    exp_t        e;
    logic [63:0] p;
    logic [31:0] w0, w1;
    logic [15:0] lo;
    e.pc = pc; e.exc = 1'b0; e.instr = 32'h0;
    p = {pc[63:1], 1'b0};
    if (atp[63:60] != 4'd0 || p < BASE || p >= BASE + SIZE) begin
      e.exc = 1'b1;
      return e;
    end
    w0 = mem[int'((p - BASE) >> 2)];
    if (!p[1]) e.instr = w0;
    else begin
      lo = w0[31:16];
      if (lo[1:0] != 2'b11) e.instr = {16'h0, lo};
      else if (p + 2 >= BASE + SIZE) e.exc = 1'b1;
      else begin
        w1 = mem[int'((p + 2 - BASE) >> 2)];
        e.instr = {w1[15:0], lo};
      end
    end
    return e;
  endfunction

  // Memory BFM: one read at a time, programmable latency and request stalls
  int          mem_lat = 1;
  int          stall_cnt = 0;
  int          cnt = 0;
  logic [63:0] cur_addr;
  logic [63:0] hold_addr;
  bit          holding = 0;
  bit          stray_req = 0;
  logic [63:0] rd_log[$];

  initial begin
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    cur_addr       = 64'h0;
    hold_addr      = 64'h0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (rst) begin
        cnt = 0; holding = 0; mem_req_ready = 1'b1;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem[int'((cur_addr - BASE) >> 2)];
          end
        end
        if (stray_req) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = 32'hDEADBEEF;
          stray_req = 0;
        end
        if (mem_req_valid) begin
          if (holding) chk("addr_stable", mem_req_addr, hold_addr);
          if (stall_cnt > 0) begin
            mem_req_ready = 1'b0;
            stall_cnt--;
            holding   = 1;
            hold_addr = mem_req_addr;
          end else begin
            chk("one_in_flight", 64'(cnt), 64'd0);
            mem_req_ready = 1'b1;
            holding  = 0;
            cur_addr = mem_req_addr;
            rd_log.push_back(mem_req_addr);
            cnt = mem_lat;
          end
        end else begin
          mem_req_ready = 1'b1;
          holding = 0;
        end
      end
    end
  end

  // Scoreboard: every response is compared with the model's prediction
  int          resp_count = 0;
  int          last_cyc = 0;
  logic [31:0] last_instr;
  logic        last_exc;

  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      exp_t e;
      resp_count++;
      last_cyc   = cyc;
      last_instr = resp_instr;
      last_exc   = resp_exception;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got pc %h with no response pending", resp_pc);
      end else begin
        e = exp_q.pop_front();
        chk("resp_pc", resp_pc, e.pc);
        chk("resp_exception", 64'(resp_exception), 64'(e.exc));
        if (!e.exc) chk("resp_instr", 64'(resp_instr), 64'(e.instr));
      end
    end
  end

  int req_cyc = 0;

  task automatic send(input logic [63:0] pc, input logic [63:0] atp, input bit expect_resp);
    @(posedge clk); #1;
    req_valid = 1'b1; req_pc = pc; req_atp = atp; req_reason = IF_FETCH;
    req_cyc = cyc;
    if (expect_resp) exp_q.push_back(model(pc, atp));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n0, input string name);
    int k = 0;
    while (resp_count == n0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (resp_count == n0) begin
      checks++; errors++;
      $display("FAIL %s: got no response expected one within 200 cycles", name);
    end
  endtask

  task automatic chk_reads(input string name, input int n, input logic [63:0] a0, input logic [63:0] a1);
    chk({name, "_nreads"}, 64'(rd_log.size()), 64'(n));
    if (n > 0 && rd_log.size() > 0) chk({name, "_rd0"}, rd_log[0], a0);
    if (n > 1 && rd_log.size() > 1) chk({name, "_rd1"}, rd_log[1], a1);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {63'h0, resp_valid | resp_exception | mem_req_valid},  64'h0);
    chk({name, "_buses"}, resp_pc | mem_req_addr | 64'(resp_instr), 64'h0);
  endtask

  logic [63:0] vec_pc [4];
  int n0;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'(i) * 32'h01010101;
    rst = 1'b1; req_valid = 1'b0; req_pc = '0; req_atp = '0;
    req_reason = IF_FETCH; req_prv = 1'b0; req_sum = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset_outputs");

    // Aligned 32-bit fetch
    mem[16'h100 >> 2] = 32'h00A00093;
    rd_log.delete(); n0 = resp_count; mem_lat = 1;
    send(64'h100, 64'h0, 1);
    wait_resp(n0, "aligned_timeout");
    chk("aligned_instr", 64'(last_instr), 64'h00A00093);
    chk("aligned_latency", 64'(last_cyc - req_cyc), 64'd3);
    chk_reads("aligned", 1, 64'h100, 64'h0);

    // Compressed instruction in the upper half
    mem[16'h100 >> 2] = 32'h45010001;
    rd_log.delete(); n0 = resp_count;
    send(64'h102, 64'h0, 1);
    wait_resp(n0, "compressed_timeout");
    chk("compressed_instr", 64'(last_instr), 64'h00004501);
    chk_reads("compressed", 1, 64'h100, 64'h0);

    // Straddling 32-bit instruction
    mem[16'h100 >> 2] = 32'h00931234;
    mem[16'h104 >> 2] = 32'hABCD00A0;
    rd_log.delete(); n0 = resp_count;
    send(64'h102, 64'h0, 1);
    wait_resp(n0, "straddle_timeout");
    chk("straddle_instr", 64'(last_instr), 64'h00A00093);
    chk("straddle_latency", 64'(last_cyc - req_cyc), 64'd5);
    chk_reads("straddle", 2, 64'h100, 64'h104);

    // Out-of-range PC faults with no memory traffic
    rd_log.delete(); n0 = resp_count;
    send(64'h10000, 64'h0, 1);
    wait_resp(n0, "range_fault_timeout");
    chk("range_fault_exc", 64'(last_exc), 64'd1);
    chk("range_fault_latency", 64'(last_cyc - req_cyc), 64'd1);
    chk_reads("range_fault", 0, 64'h0, 64'h0);

    // Translation enabled faults
    rd_log.delete(); n0 = resp_count;
    send(64'h100, 64'h8000_0000_0000_0000, 1);
    wait_resp(n0, "atp_fault_timeout");
    chk("atp_fault_exc", 64'(last_exc), 64'd1);
    chk_reads("atp_fault", 0, 64'h0, 64'h0);

    // Last halfword starts a 32-bit instruction whose second half is out of range
    mem[16383] = 32'h00030013;
    rd_log.delete(); n0 = resp_count;
    send(64'hFFFE, 64'h0, 1);
    wait_resp(n0, "edge_fault_timeout");
    chk("edge_fault_exc", 64'(last_exc), 64'd1);
    chk_reads("edge_fault", 1, 64'hFFFC, 64'h0);

    // Directed vector table, checked against the model by the scoreboard
    mem[1] = 32'h12345678;
    mem[2] = 32'hABCD0001;
    vec_pc[0] = 64'h4; vec_pc[1] = 64'h6; vec_pc[2] = 64'hA; vec_pc[3] = 64'hFFFC;
    for (int i = 0; i < 4; i++) begin
      n0 = resp_count; mem_lat = 1 + (i % 3);
      send(vec_pc[i], 64'h0, 1);
      wait_resp(n0, "vector_timeout");
    end
    chk("vector_last_instr", 64'(last_instr), 64'h00030013);

    // Supersede while waiting on slow memory
    mem[16'h200 >> 2] = 32'hCAFE0013;
    rd_log.delete(); n0 = resp_count; mem_lat = 5;
    send(64'h100, 64'h0, 0);
    send(64'h200, 64'h0, 1);
    wait_resp(n0, "supersede_timeout");
    repeat (12) @(negedge clk);
    chk("supersede_nresp", 64'(resp_count - n0), 64'd1);
    chk("supersede_instr", 64'(last_instr), 64'hCAFE0013);
    chk_reads("supersede", 2, 64'h100, 64'h200);

    // New request in the same cycle as the final data
    rd_log.delete(); n0 = resp_count; mem_lat = 3;
    send(64'h100, 64'h0, 0);
    repeat (2) @(posedge clk);
    send(64'h200, 64'h0, 1);
    wait_resp(n0, "simul_timeout");
    repeat (12) @(negedge clk);
    chk("simul_nresp", 64'(resp_count - n0), 64'd1);
    chk_reads("simul", 2, 64'h100, 64'h200);

    // Backpressure: address must stay put while ready is low
    mem[16'h300 >> 2] = 32'h00B00113;
    rd_log.delete(); n0 = resp_count; mem_lat = 1; stall_cnt = 4;
    send(64'h300, 64'h0, 1);
    wait_resp(n0, "backpressure_timeout");
    chk("backpressure_latency", 64'(last_cyc - req_cyc), 64'd7);
    chk("backpressure_instr", 64'(last_instr), 64'h00B00113);

    // Reset while waiting on memory
    rd_log.delete(); n0 = resp_count; mem_lat = 6;
    send(64'h100, 64'h0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("reset_in_wait");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    stray_req = 1;
    repeat (15) @(negedge clk);
    chk("reset_no_resp", 64'(resp_count - n0), 64'd0);
    chk_reads("reset", 1, 64'h100, 64'h0);
    chk("reset_idle_memreq", 64'(mem_req_valid), 64'd0);

    chk("expect_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
